mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares the core's single 64-bit memory port between the instruction-fetch stage and the load/store unit. It accepts one request at a time from either requester and drives it onto the memory port with a valid/ready handshake. It waits for the memory response and returns it to the owner as a one-cycle response pulse. For fetches it selects the 32-bit instruction word by address bit 2; it also supports a fetch flush for branch redirects.

## Interface
- ADDR_W, 64, address width of both requesters and the memory port
- DATA_W, 64, memory data width (fixed 64; IF word is DATA_W/2)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle when high with valid
- if_addr  in  ADDR_W  fetch PC
- if_flush  in  1  discard any fetch accepted in an earlier cycle and not yet returned
- if_resp_valid  out  1  one-cycle fetch response pulse
- if_resp_data  out  32  instruction: addr[2]=1 → mem data[63:32], else [31:0]
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted when high with valid
- ls_addr  in  ADDR_W  load/store address
- ls_we  in  1  1 = store, 0 = load
- ls_wdata  in  64  store data
- ls_wmask  in  8  store byte mask
- ls_resp_valid  out  1  one-cycle load data / store ack pulse
- ls_resp_data  out  64  raw memory data (don't-care for stores)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_we, mem_wdata, mem_wmask  out  ADDR_W/1/64/8  latched request fields
- mem_resp_valid  in  1  memory response (read data or write ack)
- mem_resp_data  in  64  read data

## Operation
- FSM states: IDLE, REQ, WAIT. Reset → IDLE.
- IDLE: `if_req_ready`/`ls_req_ready` driven combinationally; at most one is high.
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin. The grant goes to the requester not granted last. `last_grant` resets to IF, so LSU wins the first conflict.
- On handshake (valid & ready), latch owner, addr, we, wdata, wmask, and addr[2]. Update `last_grant`. Go to REQ.
- REQ: `mem_req_valid`=1 with latched fields held stable. On `mem_req_ready`, go to WAIT.
- WAIT: on `mem_resp_valid`, register the data and owner. Next cycle, pulse the owner's `*_resp_valid` for exactly one cycle. Go to IDLE.
- IF transactions are always reads: `mem_we`=0, `mem_wmask`=0.
- Flush:
  - `if_flush` high while an IF transaction is in REQ or WAIT sets `drop`.
  - The memory transaction still completes normally. The response is consumed and `if_resp_valid` is suppressed.
  - `drop` clears on return to IDLE.
  - `if_flush` in the cycle a response pulse is already registered suppresses that pulse.
  - A request accepted in the same cycle as `if_flush` is kept.
  - Flush has no effect on LSU transactions.
- `mem_resp_valid` in IDLE or REQ is ignored.
- Misaligned `if_addr[1:0]` is passed through unchanged; no exception.

## Timing
- Reset values:
  - `mem_req_valid`, `if_resp_valid`, `ls_resp_valid` = 0.
  - `if_resp_data`, `ls_resp_data`, `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_we` = 0.
  - `last_grant` = IF, `drop` = 0.
  - `*_req_ready` reflect IDLE grant logic one cycle after reset deasserts.
- Reset mid-transaction:
  - Abandons state immediately; no response pulse is issued.
  - A later memory response is ignored.
- Minimum latency with zero-wait memory:
  - Handshake at cycle 0.
  - `mem_req_valid` at cycle 1 (`mem_req_ready`=1).
  - `mem_resp_valid` at cycle 2.
  - `*_resp_valid` at cycle 3.
- Back-to-back: the cycle carrying a response pulse is an IDLE cycle, so a new request may be accepted in it. Throughput is one transaction per 3 cycles.
- `mem_req_valid` stays high and fields stay stable until `mem_req_ready`.
- Any number of REQ/WAIT stall cycles is allowed.

## Test plan
- IF only, `if_addr`=0x8000_0004, memory returns 0x1111_2222_3333_4444 with zero wait → `if_resp_valid` at cycle 3, `if_resp_data`=0x1111_2222. Repeat with 0x8000_0000 → 0x3333_4444.
- LSU store, addr 0x8000_0100, wdata 0xDEAD_BEEF_0000_0001, mask 0x0F, `mem_req_ready` low 4 cycles → fields held stable through the stall, `mem_we`=1, `ls_resp_valid` pulses once, one cycle after the ack.
- Both requesters valid continuously → grant order LSU, IF, LSU, IF. `mem_addr` alternates accordingly; never two outstanding.
- IF accepted, `if_flush` in WAIT → memory response consumed, no `if_resp_valid`. A new IF request accepted in the next IDLE returns normally.
- Reset asserted in WAIT, then `mem_resp_valid` arrives → no response pulse; state IDLE; next LSU request completes normally.
- Spurious `mem_resp_valid` while IDLE → no `*_resp_valid`, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 64-bit memory port between instruction fetch (IF) and the
// load/store unit (LS). One transaction is in flight at a time:
// IDLE (grant) -> REQ (drive memory request) -> WAIT (memory response),
// and the owner's response pulse appears in the following IDLE cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised by the initiator, holds its payload until
// the transfer. Ready may depend on valid.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_req_*, if_addr   fetch request channel
//   if_flush            drop the in-flight fetch (branch redirect)
//   if_resp_*           one-cycle fetch response, 32-bit instruction word
//   ls_req_*, ls_*      load/store request channel
//   ls_resp_*           one-cycle load data / store ack
//   mem_req_*, mem_*    memory request channel (latched fields)
//   mem_resp_*          memory response (read data or write ack)
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT)
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_resp_valid,
  output logic [DATA_W/2-1:0] if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic                  hi_q, hi_d;
  logic                  drop_q, drop_d;
  logic                  if_pulse_q, if_pulse_d;
  logic                  ls_pulse_q, ls_pulse_d;
  logic [DATA_W/2-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]     ls_data_q, ls_data_d;

  logic idle;
  logic ls_win;
  logic take_if;
  logic take_ls;
  logic resp_done;

  // Grant logic. LS wins when it is alone or when IF had the last grant,
  // which makes a conflict alternate between the two requesters.
  assign idle    = (state_q == S_IDLE);
  assign ls_win  = ls_req_valid & (~if_req_valid | (last_grant_q == OWN_IF));
  assign take_if = idle & if_req_valid & ~ls_win;
  assign take_ls = idle & ls_win;
  assign resp_done = (state_q == S_WAIT) & mem_resp_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= OWN_IF;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      hi_q         <= 1'b0;
      drop_q       <= 1'b0;
      if_pulse_q   <= 1'b0;
      ls_pulse_q   <= 1'b0;
      if_data_q    <= '0;
      ls_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      hi_q         <= hi_d;
      drop_q       <= drop_d;
      if_pulse_q   <= if_pulse_d;
      ls_pulse_q   <= ls_pulse_d;
      if_data_q    <= if_data_d;
      ls_data_q    <= ls_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    hi_d         = hi_q;
    drop_d       = drop_q;
    if_pulse_d   = 1'b0;
    ls_pulse_d   = 1'b0;
    if_data_d    = if_data_q;
    ls_data_d    = ls_data_q;

    case (state_q)
      S_IDLE: begin
        if (take_ls) begin
          state_d      = S_REQ;
          last_grant_d = OWN_LS;
          owner_d      = OWN_LS;
          addr_d       = ls_addr;
          we_d         = ls_we;
          wdata_d      = ls_wdata;
          wmask_d      = ls_wmask;
          hi_d         = ls_addr[2];
        end else if (take_if) begin
          // Fetches are always reads.
          state_d      = S_REQ;
          last_grant_d = OWN_IF;
          owner_d      = OWN_IF;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          hi_d         = if_addr[2];
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush only affects a fetch that is already past IDLE; a fetch
    // accepted in the flush cycle itself is still in IDLE here and survives.
    if (!idle && (owner_q == OWN_IF) && if_flush) drop_d = 1'b1;

    if (resp_done) begin
      drop_d = 1'b0;
      if (owner_q == OWN_IF) begin
        // Flush in the response cycle counts as well as an earlier one.
        if_pulse_d = ~drop_q & ~if_flush;
        if_data_d  = hi_q ? mem_resp_data[DATA_W-1:DATA_W/2]
                          : mem_resp_data[DATA_W/2-1:0];
      end else begin
        ls_pulse_d = 1'b1;
        ls_data_d  = mem_resp_data;
      end
    end
  end

  // Output logic
  always_comb begin
    if_req_ready  = take_if;
    ls_req_ready  = take_ls;
    mem_req_valid = (state_q == S_REQ);
    mem_addr      = addr_q;
    mem_we        = we_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
    // A flush arriving with an already-registered pulse kills that pulse.
    if_resp_valid = if_pulse_q & ~if_flush;
    if_resp_data  = if_data_q;
    ls_resp_valid = ls_pulse_q;
    ls_resp_data  = ls_data_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled 2 time units after it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [63:0] ls_addr = '0;
  logic        ls_we = 1'b0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wmask = '0;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  own_q[$];

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0; if_flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_if_resp_valid", if_resp_valid, 0);
    check("rst_ls_resp_valid", ls_resp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_fields", {mem_we, mem_wmask, mem_wdata}, 0);
    check("rst_resp_data", {if_resp_data, ls_resp_data}, 0);
  endtask

  // One transaction with zero-wait response. stall = REQ cycles with
  // mem_req_ready low; flush_at: -1 none, 0 handshake, 1 first REQ cycle,
  // 2 WAIT cycle, 3 response-pulse cycle.
  task automatic run_txn(input bit is_ls, input logic [63:0] addr, input bit we,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic [63:0] rdata, input int stall, input int flush_at,
                         input bit exp_pulse, input logic [63:0] exp_data);
    logic exp_we;
    logic [7:0] exp_mask;
    exp_we   = is_ls ? we : 1'b0;
    exp_mask = is_ls ? wmask : 8'h00;

    tick();
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_addr = addr; ls_we = we; ls_wdata = wdata; ls_wmask = wmask;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    if_flush = (flush_at == 0);
    #1;
    check("grant_if_ready", if_req_ready, !is_ls);
    check("grant_ls_ready", ls_req_ready, is_ls);

    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    if_addr = ~addr; ls_addr = ~addr; ls_wdata = ~wdata; ls_wmask = ~wmask; ls_we = ~we;
    if_flush = (flush_at == 1);
    mem_req_ready = (stall == 0);
    #1;
    check("req_valid", mem_req_valid, 1);
    check("req_addr", mem_addr, addr);
    check("req_we_mask", {mem_we, mem_wmask}, {exp_we, exp_mask});
    if (is_ls) check("req_wdata", mem_wdata, wdata);

    for (int s = 1; s <= stall; s++) begin
      tick();
      if_flush = 1'b0;
      mem_req_ready = (s == stall);
      #1;
      check("hold_valid", mem_req_valid, 1);
      check("hold_addr", mem_addr, addr);
      check("hold_we_mask", {mem_we, mem_wmask}, {exp_we, exp_mask});
      if (is_ls) check("hold_wdata", mem_wdata, wdata);
    end

    tick();
    mem_req_ready = 1'b0;
    if_flush = (flush_at == 2);
    mem_resp_valid = 1'b1; mem_resp_data = rdata;
    #1;
    check("wait_state", dbg_state, 2);
    check("wait_req_low", mem_req_valid, 0);
    check("wait_no_pulse", {if_resp_valid, ls_resp_valid}, 0);

    tick();
    mem_resp_valid = 1'b0;
    if_flush = (flush_at == 3);
    #1;
    check("pulse_if", if_resp_valid, exp_pulse && !is_ls);
    check("pulse_ls", ls_resp_valid, exp_pulse && is_ls);
    check("pulse_state", dbg_state, 0);
    if (exp_pulse && !is_ls) check("pulse_if_data", if_resp_data, exp_data);
    if (exp_pulse && is_ls && !we) check("pulse_ls_data", ls_resp_data, exp_data);

    tick();
    if_flush = 1'b0;
    #1;
    check("after_pulse_low", {if_resp_valid, ls_resp_valid}, 0);
  endtask

  task automatic run_round_robin();
    bit resp_pending = 0;
    bit done = 0;
    int hs_cnt = 0;
    int outstanding = 0;
    logic [63:0] exp_a;
    logic [1:0]  exp_o;

    exp_q = {64'h2000, 64'h1000, 64'h2000, 64'h1000};
    own_q = {2'b01, 2'b10, 2'b01, 2'b10};
    tick();
    if_req_valid = 1'b1; if_addr = 64'h1000;
    ls_req_valid = 1'b1; ls_addr = 64'h2000; ls_we = 1'b0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_resp_valid = resp_pending;
      mem_resp_data = 64'h5;
      resp_pending = 0;
      if (hs_cnt >= 4) begin
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
      end
      #1;
      check("rr_one_ready", if_req_ready & ls_req_ready, 0);
      if (if_resp_valid || ls_resp_valid) begin
        outstanding--;
        exp_o = (own_q.size() > 0) ? own_q.pop_front() : 2'b00;
        check("rr_resp_owner", {if_resp_valid, ls_resp_valid}, exp_o);
      end
      if ((if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready)) begin
        check("rr_outstanding", outstanding, 0);
        outstanding++;
        hs_cnt++;
      end
      if (mem_req_valid && mem_req_ready) begin
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check("rr_order", mem_addr, exp_a);
        resp_pending = 1;
      end
      if (hs_cnt == 4 && outstanding == 0) done = 1;
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    check("rr_done", done, 1);
    check("rr_left", exp_q.size() + own_q.size(), 0);
  endtask

  initial begin
    do_reset();

    // Fetch word select by address bit 2
    run_txn(0, 64'h8000_0004, 0, 0, 0, 64'h1111_2222_3333_4444, 0, -1, 1, 64'h1111_2222);
    run_txn(0, 64'h8000_0000, 0, 0, 0, 64'h1111_2222_3333_4444, 0, -1, 1, 64'h3333_4444);
    // Store with 4 stall cycles
    run_txn(1, 64'h8000_0100, 1, 64'hDEAD_BEEF_0000_0001, 8'h0F, 64'h0, 4, -1, 1, 64'h0);

    // Round robin from reset: LS, IF, LS, IF
    do_reset();
    run_round_robin();

    // Flush in WAIT drops the response; next fetch returns normally
    run_txn(0, 64'h8000_0010, 0, 0, 0, 64'h5555_6666_7777_8888, 0, 2, 0, 64'h0);
    run_txn(0, 64'h8000_0006, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 0, -1, 1, 64'hAAAA_BBBB);
    // Flush in REQ during a stall
    run_txn(0, 64'h8000_0020, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 2, 1, 0, 64'h0);
    // Flush in the pulse cycle
    run_txn(0, 64'h8000_0024, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 0, 3, 0, 64'h0);
    // Flush in the accept cycle does not drop the new fetch
    run_txn(0, 64'h8000_0028, 0, 0, 0, 64'h0BAD_F00D_CAFE_BABE, 1, 0, 1, 64'hCAFE_BABE);
    // Flush has no effect on a load
    run_txn(1, 64'h0000_0040, 0, 0, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 0, 2, 1, 64'h0F0E_0D0C_0B0A_0908);

    // Reset in WAIT, then a late memory response
    tick();
    ls_req_valid = 1'b1; ls_addr = 64'h300; ls_we = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("mid_grant", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    tick();
    reset = 1'b1; mem_req_ready = 1'b0;
    #1;
    check("mid_wait_state", dbg_state, 2);
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 64'h7777_7777_7777_7777;
    #1;
    check("mid_idle_state", dbg_state, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("mid_no_pulse", {if_resp_valid, ls_resp_valid}, 0);
    check("mid_still_idle", dbg_state, 0);
    run_txn(1, 64'h0000_0308, 0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, -1, 1, 64'h0123_4567_89AB_CDEF);

    // Spurious response while IDLE
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("spur_state", dbg_state, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("spur_no_pulse", {if_resp_valid, ls_resp_valid}, 0);
    check("spur_state_after", dbg_state, 0);
    check("spur_ls_data", ls_resp_data, 64'h0123_4567_89AB_CDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
